// File: rtl/rf_pkg.sv
// Shared constants and helpers for the bypassing, scoreboarded register file.
package rf_pkg;

    localparam int unsigned XLEN_DEF  = 32;
    localparam int unsigned NREGS_DEF = 32;
    localparam int unsigned REG_ZERO  = 0;

    function automatic int unsigned addr_width(input int unsigned nregs);
        return (nregs > 1) ? $clog2(nregs) : 1;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits for long-latency MDU results and the decode hazard.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter  int unsigned NREGS  = NREGS_DEF,
    parameter  int unsigned BYPASS = 1,
    localparam int unsigned AW     = addr_width(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mdu_issue,
    input  logic [AW-1:0]    mdu_issue_rd,
    input  logic             clr_en,
    input  logic [AW-1:0]    clr_rd,
    input  logic [AW-1:0]    rs1,
    input  logic [AW-1:0]    rs2,
    input  logic [AW-1:0]    chk_rd,
    input  logic             chk_rd_en,
    output logic             hazard,
    output logic [NREGS-1:0] busy_vec
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic [NREGS-1:0] eff_busy;
    logic             issue_fire;

    // An issue during a stall belongs to an instruction that is not leaving decode.
    assign issue_fire = mdu_issue & ~hazard;

    always_comb begin
        busy_d = busy_q;
        if (clr_en) begin
            busy_d[clr_rd] = 1'b0;
        end
        if (issue_fire) begin
            busy_d[mdu_issue_rd] = 1'b1;
        end
        busy_d[REG_ZERO] = 1'b0;
    end

    always_comb begin
        eff_busy = busy_q;
        if ((BYPASS != 0) && clr_en) begin
            eff_busy[clr_rd] = 1'b0;
        end
        eff_busy[REG_ZERO] = 1'b0;
    end

    assign hazard = eff_busy[rs1] | eff_busy[rs2] | (chk_rd_en & eff_busy[chk_rd]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

endmodule

// File: rtl/regfile_sb.sv
// Register file with read bypass, a second (MDU) write port, busy scoreboard
// and a registered debug read port.
module regfile_sb
    import rf_pkg::*;
#(
    parameter  int unsigned XLEN   = XLEN_DEF,
    parameter  int unsigned NREGS  = NREGS_DEF,
    parameter  int unsigned BYPASS = 1,
    localparam int unsigned AW     = addr_width(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [AW-1:0]    rs1,
    input  logic [AW-1:0]    rs2,
    output logic [XLEN-1:0]  rs1_val,
    output logic [XLEN-1:0]  rs2_val,
    input  logic             we,
    input  logic [AW-1:0]    rd,
    input  logic [XLEN-1:0]  wd,
    input  logic             mdu_issue,
    input  logic [AW-1:0]    mdu_issue_rd,
    input  logic             mdu_wb_valid,
    input  logic [AW-1:0]    mdu_wb_rd,
    input  logic [XLEN-1:0]  mdu_wb_data,
    output logic             mdu_wb_ready,
    input  logic [AW-1:0]    chk_rd,
    input  logic             chk_rd_en,
    output logic             hazard,
    output logic [NREGS-1:0] busy_vec,
    input  logic [AW-1:0]    dbg_addr,
    output logic [XLEN-1:0]  dbg_data
);

    localparam logic [AW-1:0] Zero = AW'(REG_ZERO);

    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] dbg_q;
    logic            mdu_fire;

    // Main writeback always wins the single shared commit slot.
    assign mdu_wb_ready = ~we;
    assign mdu_fire     = mdu_wb_valid & mdu_wb_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            if (we && (rd != Zero)) begin
                regs_q[rd] <= wd;
            end
            if (mdu_fire && (mdu_wb_rd != Zero)) begin
                regs_q[mdu_wb_rd] <= mdu_wb_data;
            end
        end
    end

    always_comb begin
        rs1_val = regs_q[rs1];
        if (rs1 == Zero) begin
            rs1_val = '0;
        end else if ((BYPASS != 0) && we && (rd == rs1)) begin
            rs1_val = wd;
        end else if ((BYPASS != 0) && mdu_fire && (mdu_wb_rd == rs1)) begin
            rs1_val = mdu_wb_data;
        end
    end

    always_comb begin
        rs2_val = regs_q[rs2];
        if (rs2 == Zero) begin
            rs2_val = '0;
        end else if ((BYPASS != 0) && we && (rd == rs2)) begin
            rs2_val = wd;
        end else if ((BYPASS != 0) && mdu_fire && (mdu_wb_rd == rs2)) begin
            rs2_val = mdu_wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dbg_q <= '0;
        end else begin
            dbg_q <= regs_q[dbg_addr];
        end
    end

    assign dbg_data = dbg_q;

    rf_scoreboard #(
        .NREGS  (NREGS),
        .BYPASS (BYPASS)
    ) u_scoreboard (
        .clk          (clk),
        .rst_n        (rst_n),
        .mdu_issue    (mdu_issue),
        .mdu_issue_rd (mdu_issue_rd),
        .clr_en       (mdu_fire),
        .clr_rd       (mdu_wb_rd),
        .rs1          (rs1),
        .rs2          (rs2),
        .chk_rd       (chk_rd),
        .chk_rd_en    (chk_rd_en),
        .hazard       (hazard),
        .busy_vec     (busy_vec)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb; a BYPASS=0 instance shares the stimulus.
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  rs1, rs2, rd, mdu_issue_rd, mdu_wb_rd, chk_rd, dbg_addr;
    logic [31:0] wd, mdu_wb_data;
    logic        we, mdu_issue, mdu_wb_valid, chk_rd_en;

    logic [31:0] rs1_val, rs2_val, dbg_data, busy_vec;
    logic        mdu_wb_ready, hazard;
    logic [31:0] nb_rs1_val, nb_rs2_val, nb_dbg_data, nb_busy_vec;
    logic        nb_mdu_wb_ready, nb_hazard;

    int checks = 0;
    int passed = 0;
    logic [31:0] exp_q [$];
    string       tag_q [$];

    always #5 clk = ~clk;

    regfile_sb #(.XLEN(32), .NREGS(32), .BYPASS(1)) dut (
        .clk(clk), .rst_n(rst_n), .rs1(rs1), .rs2(rs2), .rs1_val(rs1_val), .rs2_val(rs2_val),
        .we(we), .rd(rd), .wd(wd), .mdu_issue(mdu_issue), .mdu_issue_rd(mdu_issue_rd),
        .mdu_wb_valid(mdu_wb_valid), .mdu_wb_rd(mdu_wb_rd), .mdu_wb_data(mdu_wb_data),
        .mdu_wb_ready(mdu_wb_ready), .chk_rd(chk_rd), .chk_rd_en(chk_rd_en),
        .hazard(hazard), .busy_vec(busy_vec), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    regfile_sb #(.XLEN(32), .NREGS(32), .BYPASS(0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .rs1(rs1), .rs2(rs2), .rs1_val(nb_rs1_val),
        .rs2_val(nb_rs2_val), .we(we), .rd(rd), .wd(wd), .mdu_issue(mdu_issue),
        .mdu_issue_rd(mdu_issue_rd), .mdu_wb_valid(mdu_wb_valid), .mdu_wb_rd(mdu_wb_rd),
        .mdu_wb_data(mdu_wb_data), .mdu_wb_ready(nb_mdu_wb_ready), .chk_rd(chk_rd),
        .chk_rd_en(chk_rd_en), .hazard(nb_hazard), .busy_vec(nb_busy_vec),
        .dbg_addr(dbg_addr), .dbg_data(nb_dbg_data)
    );

    task automatic expect_val(input string tag, input logic [31:0] val);
        tag_q.push_back(tag);
        exp_q.push_back(val);
    endtask

    task automatic compare(input logic [31:0] obs);
        logic [31:0] want;
        string       tag;
        checks++;
        if (exp_q.size() == 0) begin
            $error("FAIL scoreboard_empty: observed %h, no expected value queued", obs);
        end else begin
            want = exp_q.pop_front();
            tag  = tag_q.pop_front();
            assert (obs === want) passed++;
            else $error("FAIL %s: observed %h expected %h", tag, obs, want);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n = 1'b0; we = 0; rd = 0; wd = 0; rs1 = 0; rs2 = 0;
        mdu_issue = 0; mdu_issue_rd = 0; mdu_wb_valid = 0; mdu_wb_rd = 0; mdu_wb_data = 0;
        chk_rd = 0; chk_rd_en = 0; dbg_addr = 5;
        tick();
        tick();
        rst_n = 1'b1;

        // Reset state: all reads zero, busy clear, debug zero.
        for (int a = 0; a < 32; a++) begin
            rs1 = 5'(a);
            rs2 = 5'(31 - a);
            expect_val("reset_rs1", 32'h0);
            expect_val("reset_rs2", 32'h0);
            #1;
            compare(rs1_val);
            compare(rs2_val);
        end
        expect_val("reset_busy", 32'h0);
        expect_val("reset_dbg", 32'h0);
        tick();
        compare(busy_vec);
        compare(dbg_data);

        // Same-cycle bypass of the main write port.
        we = 1; rd = 3; wd = 32'hDEAD_BEEF; rs1 = 3; dbg_addr = 3;
        expect_val("bypass_main", 32'hDEAD_BEEF);
        expect_val("nobypass_main", 32'h0);
        #1;
        compare(rs1_val);
        compare(nb_rs1_val);
        tick();
        we = 0;
        expect_val("stored_x3", 32'hDEAD_BEEF);
        expect_val("nb_stored_x3", 32'hDEAD_BEEF);
        #1;
        compare(rs1_val);
        compare(nb_rs1_val);
        expect_val("dbg_x3", 32'hDEAD_BEEF);
        tick();
        compare(dbg_data);

        // x0 discards writes and never becomes busy.
        we = 1; rd = 0; wd = 32'h1234; rs2 = 0; rs1 = 0;
        expect_val("x0_bypass", 32'h0);
        #1;
        compare(rs2_val);
        tick();
        we = 0; mdu_issue = 1; mdu_issue_rd = 0;
        expect_val("x0_stored", 32'h0);
        #1;
        compare(rs2_val);
        tick();
        mdu_issue = 0;
        expect_val("x0_busy", 32'h0);
        #1;
        compare(busy_vec);

        // Issue to x7, stall until the MDU result for x7 fires.
        mdu_issue = 1; mdu_issue_rd = 7;
        expect_val("issue_no_hazard", 32'h0);
        #1;
        compare(32'(hazard));
        tick();
        mdu_issue = 0; rs1 = 7;
        expect_val("x7_busy", 32'h80);
        expect_val("x7_hazard", 32'h1);
        #1;
        compare(busy_vec);
        compare(32'(hazard));
        tick();
        expect_val("x7_hazard_hold", 32'h1);
        #1;
        compare(32'(hazard));
        mdu_wb_valid = 1; mdu_wb_rd = 7; mdu_wb_data = 32'h55;
        expect_val("x7_ready", 32'h1);
        expect_val("x7_fire_hazard", 32'h0);
        expect_val("x7_fire_bypass", 32'h55);
        expect_val("nb_fire_hazard", 32'h1);
        expect_val("nb_fire_val", 32'h0);
        #1;
        compare(32'(mdu_wb_ready));
        compare(32'(hazard));
        compare(rs1_val);
        compare(32'(nb_hazard));
        compare(nb_rs1_val);
        tick();
        mdu_wb_valid = 0;
        expect_val("x7_cleared", 32'h0);
        expect_val("x7_stored", 32'h55);
        #1;
        compare(busy_vec);
        compare(rs1_val);

        // Issue while stalled is ignored.
        rs1 = 0; mdu_issue = 1; mdu_issue_rd = 8;
        tick();
        rs1 = 8; mdu_issue_rd = 11;
        tick();
        mdu_issue = 0;
        expect_val("stalled_issue", 32'h100);
        #1;
        compare(busy_vec);
        mdu_wb_valid = 1; mdu_wb_rd = 8; mdu_wb_data = 32'h88;
        tick();
        mdu_wb_valid = 0; rs1 = 0;

        // Main port has priority over a pending MDU result.
        mdu_issue = 1; mdu_issue_rd = 9;
        tick();
        mdu_issue = 0;
        we = 1; rd = 4; wd = 32'h44;
        mdu_wb_valid = 1; mdu_wb_rd = 9; mdu_wb_data = 32'h99;
        expect_val("arb_blocked", 32'h0);
        #1;
        compare(32'(mdu_wb_ready));
        tick();
        we = 0; rs1 = 9; rs2 = 4;
        expect_val("arb_x9_not_written", 32'h0);
        expect_val("arb_ready", 32'h1);
        #1;
        compare(nb_rs1_val);
        compare(32'(mdu_wb_ready));
        tick();
        mdu_wb_valid = 0;
        expect_val("arb_x4", 32'h44);
        expect_val("arb_x9", 32'h99);
        expect_val("arb_busy", 32'h0);
        #1;
        compare(rs2_val);
        compare(rs1_val);
        compare(busy_vec);

        // Set wins over a same-cycle clear; WAW check through chk_rd.
        rs1 = 0; rs2 = 0; mdu_issue = 1; mdu_issue_rd = 12;
        tick();
        mdu_wb_valid = 1; mdu_wb_rd = 12; mdu_wb_data = 32'hC0;
        tick();
        mdu_issue = 0; mdu_wb_valid = 0;
        chk_rd = 12; chk_rd_en = 1;
        expect_val("set_wins", 32'h1000);
        expect_val("waw_hazard", 32'h1);
        #1;
        compare(busy_vec);
        compare(32'(hazard));
        chk_rd_en = 0;
        expect_val("waw_disabled", 32'h0);
        #1;
        compare(32'(hazard));

        // Asynchronous reset between edges, then a later MDU result still lands.
        mdu_issue = 1; mdu_issue_rd = 10;
        tick();
        mdu_issue = 0; rs1 = 3; rs2 = 9;
        #1;
        rst_n = 1'b0;
        expect_val("async_busy", 32'h0);
        expect_val("async_x3", 32'h0);
        expect_val("async_x9", 32'h0);
        #1;
        compare(busy_vec);
        compare(rs1_val);
        compare(rs2_val);
        #1;
        rst_n = 1'b1;
        tick();
        mdu_wb_valid = 1; mdu_wb_rd = 10; mdu_wb_data = 32'hAA;
        expect_val("post_reset_ready", 32'h1);
        #1;
        compare(32'(mdu_wb_ready));
        tick();
        mdu_wb_valid = 0; rs1 = 10; dbg_addr = 10;
        expect_val("post_reset_x10", 32'hAA);
        #1;
        compare(nb_rs1_val);
        expect_val("post_reset_dbg", 32'hAA);
        tick();
        compare(dbg_data);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule
